// File: rtl/id_stage_pipe.sv
// Instruction decode stage: ARM-style decoder, register file, ID/EX register.
// Define ID_WB_BYPASS_EN to forward same-cycle write-back data to reads.
module id_stage_pipe #(
  parameter int BIT_NUMBER   = 32,
  parameter int REG_NUM_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BIT_NUMBER-1:0]   pc_in,
  input  logic [BIT_NUMBER-1:0]   instruction_in,
  input  logic                    hazard,
  input  logic                    flush,
  input  logic [3:0]              sr,
  input  logic                    wb_en_in,
  input  logic [REG_NUM_BITS-1:0] dest_wb,
  input  logic [BIT_NUMBER-1:0]   result_wb,
  output logic [BIT_NUMBER-1:0]   pc,
  output logic [BIT_NUMBER-1:0]   val_rn,
  output logic [BIT_NUMBER-1:0]   val_rm,
  output logic [3:0]              exe_cmd,
  output logic [REG_NUM_BITS-1:0] dest,
  output logic [11:0]             shift_operand,
  output logic [23:0]             signed_imm_24,
  output logic                    wb_en,
  output logic                    mem_r_en,
  output logic                    mem_w_en,
  output logic                    b,
  output logic                    s,
  output logic                    imm,
  output logic                    valid,
  output logic [REG_NUM_BITS-1:0] src1,
  output logic [REG_NUM_BITS-1:0] src2,
  output logic                    two_src
);

  localparam int NREG = 1 << REG_NUM_BITS;

  logic [3:0]              cond;
  logic [1:0]              mode;
  logic                    i_bit;
  logic [3:0]              opcode;
  logic                    s_bit;
  logic [REG_NUM_BITS-1:0] rn;
  logic [REG_NUM_BITS-1:0] rd;
  logic [REG_NUM_BITS-1:0] rm;

  assign cond   = instruction_in[31:28];
  assign mode   = instruction_in[27:26];
  assign i_bit  = instruction_in[25];
  assign opcode = instruction_in[24:21];
  assign s_bit  = instruction_in[20];
  assign rn     = REG_NUM_BITS'(instruction_in[19:16]);
  assign rd     = REG_NUM_BITS'(instruction_in[15:12]);
  assign rm     = REG_NUM_BITS'(instruction_in[3:0]);

  logic n_f, z_f, c_f, v_f;
  assign {n_f, z_f, c_f, v_f} = sr;

  logic cond_ok;
  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      4'b0000: cond_ok = z_f;
      4'b0001: cond_ok = !z_f;
      4'b0010: cond_ok = c_f;
      4'b0011: cond_ok = !c_f;
      4'b0100: cond_ok = n_f;
      4'b0101: cond_ok = !n_f;
      4'b0110: cond_ok = v_f;
      4'b0111: cond_ok = !v_f;
      4'b1000: cond_ok = c_f && !z_f;
      4'b1001: cond_ok = !c_f || z_f;
      4'b1010: cond_ok = (n_f == v_f);
      4'b1011: cond_ok = (n_f != v_f);
      4'b1100: cond_ok = !z_f && (n_f == v_f);
      4'b1101: cond_ok = z_f || (n_f != v_f);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  logic       dec_ok;
  logic [3:0] dec_cmd;
  logic       dec_wb;
  logic       dec_mr;
  logic       dec_mw;
  logic       dec_b;
  logic       dec_s;

  always_comb begin
    dec_ok  = 1'b0;
    dec_cmd = 4'b0000;
    dec_wb  = 1'b0;
    dec_mr  = 1'b0;
    dec_mw  = 1'b0;
    dec_b   = 1'b0;
    dec_s   = 1'b0;
    unique case (mode)
      2'b00: begin
        dec_ok = 1'b1;
        dec_wb = 1'b1;
        dec_s  = s_bit;
        case (opcode)
          4'b1101: dec_cmd = 4'b0001;
          4'b1111: dec_cmd = 4'b1001;
          4'b0100: dec_cmd = 4'b0010;
          4'b0101: dec_cmd = 4'b0011;
          4'b0010: dec_cmd = 4'b0100;
          4'b0110: dec_cmd = 4'b0101;
          4'b0000: dec_cmd = 4'b0110;
          4'b1100: dec_cmd = 4'b0111;
          4'b0001: dec_cmd = 4'b1000;
          4'b1010: begin
            dec_cmd = 4'b0100;
            dec_wb  = 1'b0;
          end
          4'b1000: begin
            dec_cmd = 4'b0110;
            dec_wb  = 1'b0;
          end
          default: dec_ok = 1'b0;
        endcase
      end
      2'b01: begin
        dec_ok  = 1'b1;
        dec_cmd = 4'b0010;
        dec_mr  = s_bit;
        dec_wb  = s_bit;
        dec_mw  = !s_bit;
      end
      2'b10: begin
        dec_ok = 1'b1;
        dec_b  = 1'b1;
      end
      default: dec_ok = 1'b0;
    endcase
  end

  // Source indices go to the hazard unit even when the result is squashed.
  assign src1    = rn;
  assign src2    = dec_mw ? rd : rm;
  assign two_src = !i_bit || dec_mw;

  logic [BIT_NUMBER-1:0] rf_q [NREG];
  logic [BIT_NUMBER-1:0] rd1;
  logic [BIT_NUMBER-1:0] rd2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NREG; k++) rf_q[k] <= '0;
    end else if (wb_en_in) begin
      rf_q[dest_wb] <= result_wb;
    end
  end

`ifdef ID_WB_BYPASS_EN
  assign rd1 = (wb_en_in && dest_wb == src1) ? result_wb : rf_q[src1];
  assign rd2 = (wb_en_in && dest_wb == src2) ? result_wb : rf_q[src2];
`else
  assign rd1 = rf_q[src1];
  assign rd2 = rf_q[src2];
`endif

  logic live;
  assign live = dec_ok && cond_ok && !flush && !hazard;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc            <= '0;
      val_rn        <= '0;
      val_rm        <= '0;
      exe_cmd       <= '0;
      dest          <= '0;
      shift_operand <= '0;
      signed_imm_24 <= '0;
      wb_en         <= 1'b0;
      mem_r_en      <= 1'b0;
      mem_w_en      <= 1'b0;
      b             <= 1'b0;
      s             <= 1'b0;
      imm           <= 1'b0;
      valid         <= 1'b0;
    end else begin
      pc            <= pc_in;
      val_rn        <= rd1;
      val_rm        <= rd2;
      dest          <= rd;
      shift_operand <= instruction_in[11:0];
      signed_imm_24 <= instruction_in[23:0];
      imm           <= i_bit;
      exe_cmd       <= live ? dec_cmd : 4'b0000;
      wb_en         <= live && dec_wb;
      mem_r_en      <= live && dec_mr;
      mem_w_en      <= live && dec_mw;
      b             <= live && dec_b;
      s             <= live && dec_s;
      valid         <= live;
    end
  end

endmodule

// File: doc/id_stage_pipe.md
ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

Interface
REQ-001 SHALL have parameter BIT_NUMBER, default 32, datapath width.
REQ-002 SHALL have parameter REG_NUM_BITS, default 4, register index width; register file holds 2^REG_NUM_BITS entries.
REQ-003 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-low reset (fixed).
REQ-004 SHALL have inputs: pc_in  BIT_NUMBER  fetch PC; instruction_in  BIT_NUMBER  fetched instruction; hazard  1  insert bubble; flush  1  branch-taken kill; sr  4  status NZCV; wb_en_in  1  write-back enable; dest_wb  REG_NUM_BITS  write-back index; result_wb  BIT_NUMBER  write-back data.
REQ-005 SHALL have registered outputs: pc, val_rn, val_rm  BIT_NUMBER; exe_cmd  4; dest  REG_NUM_BITS; shift_operand  12; signed_imm_24  24; wb_en, mem_r_en, mem_w_en, b, s, imm, valid  1 each.
REQ-006 SHALL have combinational outputs src1, src2  REG_NUM_BITS and two_src  1 for the hazard unit.

Function
REQ-007 SHALL decode fields: cond [31:28], mode [27:26], I [25], opcode [24:21], S/L [20], Rn [19:16], Rd [15:12], shift_operand [11:0], Rm [3:0], imm24 [23:0].
REQ-008 SHALL map mode 00 opcodes to exe_cmd: MOV 1101->0001, MVN 1111->1001, ADD 0100->0010, ADC 0101->0011, SUB 0010->0100, SBC 0110->0101, AND 0000->0110, ORR 1100->0111, EOR 0001->1000, CMP 1010->0100, TST 1000->0110; other opcodes SHALL produce a bubble.
REQ-009 SHALL treat mode 01 as LDR (L=1: mem_r_en, wb_en) or STR (L=0: mem_w_en), exe_cmd 0010; mode 10 as branch (b=1, no wb_en); mode 11 SHALL produce a bubble.
REQ-010 SHALL assert wb_en for all data-processing ops except CMP/TST; s SHALL follow bit 20 for mode 00 and be 0 otherwise.
REQ-011 SHALL evaluate cond against sr for all 15 ARM conditions (EQ..AL, 1111 never); failed condition SHALL produce a bubble.
REQ-012 SHALL set src1=Rn, src2 = Rd when mem_w_en else Rm; two_src = ~I | mem_w_en.
REQ-013 SHALL hold a register file written at posedge clk when wb_en_in=1 at index dest_wb; reads SHALL be combinational on src1/src2.
REQ-014 SHALL register all outputs of REQ-005 at posedge clk, one-cycle latency from instruction_in.
REQ-015 Bubble SHALL mean wb_en, mem_r_en, mem_w_en, b, s, valid = 0 and exe_cmd=0000; data fields SHALL still load.
REQ-016 flush=1 or hazard=1 SHALL load a bubble; flush SHALL take priority; simultaneous flush and write-back SHALL still update the register file.
REQ-017 valid SHALL be 1 for every non-bubble decoded instruction.

Reset
REQ-018 rst=0 SHALL immediately clear all registered outputs and every register-file entry to 0, including mid-operation; first decode SHALL occur at the first posedge after rst deasserts.

Configuration
REQ-019 With macro ID_WB_BYPASS_EN defined, a read of index equal to dest_wb while wb_en_in=1 SHALL return result_wb in the same cycle.
REQ-020 Without ID_WB_BYPASS_EN, such a read SHALL return the pre-write register value.

Verification
REQ-021 Reset then ADD R1,R2,R3 (0xE0821003) with R2=5,R3=7 -> next cycle exe_cmd=0010, wb_en=1, dest=1, val_rn=5, val_rm=7, valid=1.
REQ-022 CMP R1,R2 (0xE1510002) -> wb_en=0, s=1, exe_cmd=0100; STR R4,[R1] -> mem_w_en=1, src2=4, two_src=1.
REQ-023 BEQ (0x0A000010) with sr Z=0 -> bubble, valid=0; with Z=1 -> b=1, signed_imm_24=0x000010.
REQ-024 hazard=1 with valid ADD -> bubble; flush=1 and hazard=1 together -> bubble; wb_en_in=1 same cycle -> register still written.
REQ-025 wb_en_in=1, dest_wb=2, result_wb=0xDEAD with ADD reading R2 -> val_rn=0xDEAD when ID_WB_BYPASS_EN defined, old value otherwise.
REQ-026 rst pulsed low mid-stream -> all outputs 0 asynchronously, R0..R15 read 0 afterwards.
